// File: rtl/sram_burst_ctrl.sv
// Burst controller between a request/stream interface and a single-port synchronous SRAM.
// Write bursts stream one word per accepted cycle; read bursts take three cycles per word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; latches start address and length
// WRITE   | streaming wr_data into SRAM, one word per wr_valid cycle
// RD_ADDR | SRAM address presented for a read
// RD_CAP  | SRAM output valid; captured into rd_data at the edge
// RD_OUT  | rd_data offered to the consumer until rd_ready
// DONE    | one-cycle completion pulse
module sram_burst_ctrl #(
  parameter int datawidth    = 8,
  parameter int addresswidth = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [addresswidth-1:0] req_addr,
  input  logic [addresswidth-1:0] req_len,
  input  logic [datawidth-1:0]    wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [datawidth-1:0]    rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_we,
  output logic [addresswidth-1:0] mem_addr,
  output logic [datawidth-1:0]    mem_din,
  input  logic [datawidth-1:0]    mem_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    RD_OUT  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [addresswidth-1:0] addr, addr_nxt;
  logic [addresswidth-1:0] count, count_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      count <= count_nxt;
      if (state == RD_CAP) rd_data <= mem_dout;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    count_nxt = count;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          addr_nxt  = req_addr;
          count_nxt = req_len;
          state_nxt = req_write ? WRITE : RD_ADDR;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        mem_we   = wr_valid;
        if (wr_valid) begin
          addr_nxt = addr + addresswidth'(1);
          if (count == '0) state_nxt = DONE;
          else             count_nxt = count - addresswidth'(1);
        end
      end
      RD_ADDR: state_nxt = RD_CAP;
      RD_CAP:  state_nxt = RD_OUT;
      RD_OUT: begin
        rd_valid = 1'b1;
        // rd_data and addr hold while the consumer stalls
        if (rd_ready) begin
          addr_nxt = addr + addresswidth'(1);
          if (count == '0) begin
            state_nxt = DONE;
          end else begin
            count_nxt = count - addresswidth'(1);
            state_nxt = RD_ADDR;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr = addr;
  assign mem_din  = wr_data;

endmodule
